// File: rtl/led_game_pattern_gen_if.sv
// Controller-to-pattern-engine bundle: game controls in, LED frame and game events out.
interface led_game_pattern_gen_if #(
  parameter int NUM_LEDS = 5,
  parameter int POS_W    = $clog2(NUM_LEDS)
);
  logic [1:0]            mode;
  logic [2:0]            lvl;
  logic                  press;
  logic [24*NUM_LEDS-1:0] grb_seq;
  logic                  step;
  logic [POS_W-1:0]      cursor_pos;
  logic                  hit;
  logic                  miss;
  logic                  flash_done;

  modport master (
    output mode, lvl, press,
    input  grb_seq, step, cursor_pos, hit, miss, flash_done
  );

  modport slave (
    input  mode, lvl, press,
    output grb_seq, step, cursor_pos, hit, miss, flash_done
  );
endinterface

// File: rtl/led_game_pattern_gen.sv
// Reaction-game LED pattern engine: level-paced step counter, idle/run/flash FSM,
// GRB frame builder and press judging against the centre pixel.
module led_game_pattern_gen #(
  parameter int NUM_LEDS    = 5,
  parameter int CNT_W       = 27,
  parameter int MAX_LVL     = 4,
  parameter int FLASH_COUNT = 3,
  parameter int POS_W       = $clog2(NUM_LEDS)
) (
  input  logic                  clk,
  input  logic                  reset,
  led_game_pattern_gen_if.slave bus
);
  localparam int          CENTER = NUM_LEDS / 2;
  localparam int          FC_W   = $clog2(FLASH_COUNT + 1);
  localparam logic [23:0] RED    = 24'h00FF00;
  localparam logic [23:0] OFF    = 24'h000000;

  typedef enum logic [2:0] {
    IDLE_ON  = 3'd0,
    IDLE_OFF = 3'd1,
    RUN      = 3'd2,
    FL_ON    = 3'd3,
    FL_OFF   = 3'd4,
    FL_DONE  = 3'd5
  } state_t;

  function automatic logic [23:0] level_colour(input logic [2:0] l);
    logic [23:0] c;
    case (l)
      3'd0:    c = 24'h66FF00;
      3'd1:    c = 24'hFF0000;
      3'd2:    c = 24'hFF00FF;
      3'd3:    c = 24'h0000FF;
      default: c = 24'h0066FF;
    endcase
    return c;
  endfunction

  // Terminal count for a level: 2^(CNT_W-1-l) - 1.
  function automatic logic [CNT_W-1:0] terminal(input logic [2:0] l);
    return (CNT_W'(1) << (CNT_W - 1 - int'(l))) - CNT_W'(1);
  endfunction

  state_t                 state_r, state_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic [1:0]             mode_q_r;
  logic [POS_W-1:0]       pos_r, pos_s;
  logic                   dir_up_r, dir_up_s;
  logic [FC_W-1:0]        fcnt_r, fcnt_s, fcnt_inc_s;
  logic                   hit_r, miss_r, flash_done_r;
  logic [2:0]             lvl_c_s;
  logic                   step_s, mode_chg_s;
  logic [24*NUM_LEDS-1:0] frame_s;

  assign lvl_c_s    = (bus.lvl > 3'(MAX_LVL)) ? 3'(MAX_LVL) : bus.lvl;
  assign step_s     = (cnt_r == terminal(lvl_c_s));
  assign mode_chg_s = (bus.mode != mode_q_r);
  assign fcnt_inc_s = fcnt_r + FC_W'(1);

  // Next-state logic for FSM, step counter, cursor and flash counter.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    pos_s    = pos_r;
    dir_up_s = dir_up_r;
    fcnt_s   = fcnt_r;
    if (mode_chg_s) begin
      cnt_s    = {CNT_W{1'b0}};
      pos_s    = {POS_W{1'b0}};
      dir_up_s = 1'b1;
      fcnt_s   = {FC_W{1'b0}};
      case (bus.mode)
        2'd0:    state_s = IDLE_ON;
        2'd1:    state_s = RUN;
        default: state_s = FL_ON;
      endcase
    end else if (step_s) begin
      cnt_s = {CNT_W{1'b0}};
      case (state_r)
        IDLE_ON:  state_s = IDLE_OFF;
        IDLE_OFF: state_s = IDLE_ON;
        RUN: begin
          if (dir_up_r) begin
            if (pos_r == POS_W'(NUM_LEDS - 1)) begin
              pos_s    = POS_W'(NUM_LEDS - 2);
              dir_up_s = 1'b0;
            end else begin
              pos_s = pos_r + POS_W'(1);
            end
          end else begin
            if (pos_r == {POS_W{1'b0}}) begin
              pos_s    = POS_W'(1);
              dir_up_s = 1'b1;
            end else begin
              pos_s = pos_r - POS_W'(1);
            end
          end
        end
        FL_ON:  state_s = FL_OFF;
        FL_OFF: begin
          fcnt_s = fcnt_inc_s;
          if (fcnt_inc_s < FC_W'(FLASH_COUNT)) begin
            state_s = FL_ON;
          end else begin
            state_s = FL_DONE;
          end
        end
        FL_DONE: state_s = FL_DONE;
        default: state_s = IDLE_ON;
      endcase
    end else begin
      cnt_s = cnt_r + CNT_W'(1);
    end
  end

  // FSM state, counter and cursor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE_ON;
      cnt_r    <= {CNT_W{1'b0}};
      mode_q_r <= 2'd0;
      pos_r    <= {POS_W{1'b0}};
      dir_up_r <= 1'b1;
      fcnt_r   <= {FC_W{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      mode_q_r <= bus.mode;
      pos_r    <= pos_s;
      dir_up_r <= dir_up_s;
      fcnt_r   <= fcnt_s;
    end
  end

  // Event pulses: press judged on the pre-step cursor, flash completion on FL_DONE entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_r        <= 1'b0;
      miss_r       <= 1'b0;
      flash_done_r <= 1'b0;
    end else begin
      hit_r        <= bus.press && (state_r == RUN) && (pos_r == POS_W'(CENTER));
      miss_r       <= bus.press && (state_r == RUN) && (pos_r != POS_W'(CENTER));
      flash_done_r <= (state_s == FL_DONE) && (state_r != FL_DONE);
    end
  end

  // Frame builder; LED0 lands in the most significant 24 bits.
  always_comb begin : frame_build
    logic [23:0] px;
    logic [23:0] lc;
    frame_s = {(24*NUM_LEDS){1'b0}};
    lc      = level_colour(lvl_c_s);
    px      = OFF;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (state_r)
        IDLE_ON: px = (i == CENTER) ? RED : OFF;
        RUN: begin
          if (pos_r == POS_W'(i)) begin
            px = RED;
          end else if (i == CENTER) begin
            px = OFF;
          end else begin
            px = lc;
          end
        end
        FL_ON:   px = (mode_q_r == 2'd3) ? RED : lc;
        default: px = OFF;
      endcase
      frame_s[24*(NUM_LEDS-1-i) +: 24] = px;
    end
  end

  assign bus.grb_seq    = frame_s;
  assign bus.step       = step_s;
  assign bus.cursor_pos = pos_r;
  assign bus.hit        = hit_r;
  assign bus.miss       = miss_r;
  assign bus.flash_done = flash_done_r;
endmodule

// File: tb/tb_led_game_pattern_gen.sv
// Directed bench for led_game_pattern_gen with CNT_W=6, NUM_LEDS=5, FLASH_COUNT=3.
module tb_led_game_pattern_gen;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   n;

  localparam logic [23:0] R = 24'h00FF00;
  localparam logic [23:0] O = 24'h000000;
  localparam logic [23:0] V = 24'h0066FF;
  localparam logic [23:0] G = 24'hFF0000;
  localparam logic [119:0] IDLE_FR = {O, O, R, O, O};
  localparam logic [119:0] OFF_FR  = {O, O, O, O, O};
  localparam logic [119:0] RUN0_FR = {R, V, O, V, V};
  localparam logic [119:0] RUN2_FR = {V, V, R, V, V};
  localparam logic [119:0] RED_FR  = {R, R, R, R, R};
  localparam logic [119:0] GRN_FR  = {G, G, G, G, G};

  int seq_pos [0:8] = '{1, 2, 3, 4, 3, 2, 1, 0, 1};

  led_game_pattern_gen_if #(.NUM_LEDS(5)) bus ();

  led_game_pattern_gen #(
    .NUM_LEDS(5), .CNT_W(6), .MAX_LVL(4), .FLASH_COUNT(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance negedges until step is seen; cnt = negedges taken, -1 if budget ran out.
  task automatic wait_step(input int budget, output int cnt);
    cnt = -1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.step === 1'b1) begin
        cnt = k;
        break;
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; bus.mode = 2'd0; bus.lvl = 3'd0; bus.press = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_frame", bus.grb_seq, IDLE_FR);
    chk("reset_step", 120'(bus.step), 120'(0));
    chk("reset_pos", 120'(bus.cursor_pos), 120'(0));
    chk("reset_flags", 120'({bus.hit, bus.miss, bus.flash_done}), 120'(0));
    reset = 1'b0;

    // Idle blink at lvl 0: 32-clock period
    wait_step(40, n);        chk("idle_first_step", 120'(n), 120'(31));
    @(negedge clk);          chk("idle_off_frame", bus.grb_seq, OFF_FR);
    wait_step(40, n);        chk("idle_step2", 120'(n), 120'(31));
    wait_step(40, n);        chk("idle_period", 120'(n), 120'(32));

    // Run mode at lvl 4
    bus.mode = 2'd1; bus.lvl = 3'd4;
    @(negedge clk);
    chk("run_entry_pos", 120'(bus.cursor_pos), 120'(0));
    chk("run_entry_frame", bus.grb_seq, RUN0_FR);
    chk("run_entry_step", 120'(bus.step), 120'(0));
    for (int k = 0; k < 9; k++) begin
      wait_step(4, n);
      chk("run_step_lat", 120'(n), 120'(1));
      @(negedge clk);
      chk($sformatf("run_pos%0d", k), 120'(bus.cursor_pos), 120'(seq_pos[k]));
    end

    // lvl 7 clamps to lvl 4
    bus.lvl = 3'd7;
    wait_step(4, n);         chk("lvl7_lat", 120'(n), 120'(1));
    wait_step(4, n);         chk("lvl7_period", 120'(n), 120'(2));
    chk("lvl7_frame", bus.grb_seq, RUN2_FR);

    // Press coincident with a step from pos 2 -> hit
    bus.press = 1'b1;
    @(negedge clk); bus.press = 1'b0;
    chk("press_step_hit", 120'({bus.hit, bus.miss}), 120'(2'b10));
    chk("press_step_pos", 120'(bus.cursor_pos), 120'(3));
    // Press at pos 3 -> miss
    bus.press = 1'b1;
    @(negedge clk); bus.press = 1'b0;
    chk("press_miss", 120'({bus.hit, bus.miss}), 120'(2'b01));
    @(negedge clk);
    chk("miss_one_cycle", 120'({bus.hit, bus.miss}), 120'(0));
    chk("pos4", 120'(bus.cursor_pos), 120'(4));
    wait_step(4, n); @(negedge clk);
    wait_step(4, n); @(negedge clk);
    chk("pos2_down", 120'(bus.cursor_pos), 120'(2));
    // Press at pos 2 between steps -> hit
    bus.press = 1'b1;
    @(negedge clk); bus.press = 1'b0;
    chk("press_hit", 120'({bus.hit, bus.miss}), 120'(2'b10));
    @(negedge clk);
    chk("hit_one_cycle", 120'({bus.hit, bus.miss}), 120'(0));

    // lvl 0 applied where lvl 4 would step: no step until cnt reaches 31
    @(negedge clk);
    chk("pre_lvl_step", 120'(bus.step), 120'(1));
    bus.lvl = 3'd0; #1;
    chk("lvl_change_nostep", 120'(bus.step), 120'(0));
    wait_step(40, n);        chk("lvl0_after_change", 120'(n), 120'(30));
    @(negedge clk);
    repeat (5) @(negedge clk);
    // cnt=5 exceeds lvl 4 terminal: counts on through wrap
    bus.lvl = 3'd4; #1;
    chk("lvl_up_nostep", 120'(bus.step), 120'(0));
    wait_step(100, n);       chk("lvl4_wrap", 120'(n), 120'(60));

    // Idle: press ignored
    bus.mode = 2'd0;
    @(negedge clk);
    chk("idle_reentry", bus.grb_seq, IDLE_FR);
    bus.press = 1'b1;
    @(negedge clk); bus.press = 1'b0;
    chk("idle_press", 120'({bus.hit, bus.miss}), 120'(0));

    // Flash BAD at lvl 4
    bus.mode = 2'd3;
    @(negedge clk);
    chk("bad_on0", bus.grb_seq, RED_FR);
    chk("bad_fd0", 120'(bus.flash_done), 120'(0));
    for (int k = 0; k < 6; k++) begin
      wait_step(4, n);
      @(negedge clk);
      chk($sformatf("bad_frame%0d", k), bus.grb_seq, (k == 1 || k == 3) ? RED_FR : OFF_FR);
      chk($sformatf("bad_fd%0d", k), 120'(bus.flash_done), (k == 5) ? 120'(1) : 120'(0));
    end
    @(negedge clk);
    chk("fd_one_cycle", 120'(bus.flash_done), 120'(0));
    wait_step(4, n); @(negedge clk);
    chk("done_hold", bus.grb_seq, OFF_FR);
    chk("done_hold_fd", 120'(bus.flash_done), 120'(0));

    // Flash OK at lvl 1: green, 16-clock period
    bus.mode = 2'd2; bus.lvl = 3'd1;
    @(negedge clk);
    chk("ok_on0", bus.grb_seq, GRN_FR);
    wait_step(40, n);        chk("ok_lat", 120'(n), 120'(15));
    @(negedge clk);
    chk("ok_off", bus.grb_seq, OFF_FR);

    // Reset mid-flash
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_frame", bus.grb_seq, IDLE_FR);
    chk("midrst_step", 120'(bus.step), 120'(0));
    chk("midrst_pos", 120'(bus.cursor_pos), 120'(0));
    bus.mode = 2'd1; bus.lvl = 3'd4;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rerun_frame", bus.grb_seq, RUN0_FR);
    wait_step(4, n); @(negedge clk);
    wait_step(4, n); @(negedge clk);
    chk("rerun_pos2", 120'(bus.cursor_pos), 120'(2));

    // Mode 1 -> 3 mid-run: fresh flash, counter and cursor cleared
    bus.mode = 2'd3;
    @(negedge clk);
    chk("run2flash_frame", bus.grb_seq, RED_FR);
    chk("run2flash_pos", 120'(bus.cursor_pos), 120'(0));
    chk("run2flash_step", 120'(bus.step), 120'(0));
    wait_step(4, n);         chk("run2flash_cnt", 120'(n), 120'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
